// File: rtl/div_issue_stage.sv
// Issue/retire stage for the combinational integer divider. It queues operand pairs,
// drives one pair at a time into the divider and registers the result with divide-by-zero interception.
module div_issue_stage #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_r,
    output logic             out_dbz,
    output logic [7:0]       dbz_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

    // Valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
    // valid and its payload stay stable until that edge, and ready never depends on valid.

    state_t           state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [WIDTH-1:0] mem_b_q [DEPTH];
    logic [WIDTH-1:0] div_a_q, div_a_d;
    logic [WIDTH-1:0] div_b_q, div_b_d;
    logic [WIDTH-1:0] out_q_q, out_q_d;
    logic [WIDTH-1:0] out_r_q, out_r_d;
    logic             out_valid_q, out_valid_d;
    logic             out_dbz_q, out_dbz_d;
    logic [7:0]       dbz_count_q, dbz_count_d;
    logic             push, pop, empty;

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
    assign in_ready = (count_q != FULL_CNT);
    assign empty    = (count_q == '0);
    assign push     = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        out_q_d     = out_q_q;
        out_r_d     = out_r_q;
        out_valid_d = out_valid_q;
        out_dbz_d   = out_dbz_q;
        dbz_count_d = dbz_count_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    div_a_d = mem_a_q[rd_ptr_q];
                    div_b_d = mem_b_q[rd_ptr_q];
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (div_b_q != '0) begin
                    out_q_d   = div_q;
                    out_r_d   = div_r;
                    out_dbz_d = 1'b0;
                end else begin
                    out_q_d   = '1;
                    out_r_d   = div_a_q;
                    out_dbz_d = 1'b1;
                    if (dbz_count_q != 8'hFF) dbz_count_d = dbz_count_q + 8'd1;
                end
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (!empty) begin
                        pop     = 1'b1;
                        div_a_d = mem_a_q[rd_ptr_q];
                        div_b_d = mem_b_q[rd_ptr_q];
                        state_d = EVAL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= in_a;
            mem_b_q[wr_ptr_q] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            out_q_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            out_dbz_q   <= 1'b0;
            dbz_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            out_q_q     <= out_q_d;
            out_r_q     <= out_r_d;
            out_valid_q <= out_valid_d;
            out_dbz_q   <= out_dbz_d;
            dbz_count_q <= dbz_count_d;
        end
    end

    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign out_q     = out_q_q;
    assign out_r     = out_r_q;
    assign out_valid = out_valid_q;
    assign out_dbz   = out_dbz_q;
    assign dbz_count = dbz_count_q;
endmodule
